riscv_bp: RTL and testbench
===========================

Name: riscv_bp

Overview:
Gshare-style global-history branch predictor for the IF stage. It is the consumer end of the branch-unit predictor interface: the branch unit returns resolved branch outcomes (bu_bp_update, bu_bp_btaken, bu_bp_predict, bu_bp_history), and this block updates its pattern history table (PHT) from them. It also supplies the 2-bit prediction for every fetch address; that prediction travels down the pipe as id_bp_predict.

Parameters:
XLEN, 32, datapath/PC width
BP_GLOBAL_BITS, 2, global history bits used in the PHT index
BP_LOCAL_BITS, 10, PC bits used in the PHT index
HAS_RVC, 0, nonzero selects PC alignment shift of 1 instead of 2
INIT_STATE, 2'b01, counter value written to every entry during the init sweep

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
if_stall  input  1  IF hold; freezes the prediction output
if_nxt_pc  input  XLEN  address fetched next cycle (read address)
bp_bp_predict  output  2  PHT counter for the fetch address, valid 1 cycle after if_nxt_pc
bp_init_busy  output  1  high while the PHT init sweep runs
ex_pc  input  XLEN  PC of the branch currently reported on bu_bp_*
bu_bp_update  input  1  resolved conditional branch; write the PHT
bu_bp_btaken  input  1  resolved outcome
bu_bp_predict  input  2  counter value originally predicted for this branch
bu_bp_history  input  BP_GLOBAL_BITS  global history excluding the current branch

Behaviour:
- Clock clk; reset rstn, asynchronous, active-low.
- ALIGN = 1 if HAS_RVC else 2. Index width IW = BP_GLOBAL_BITS + BP_LOCAL_BITS. PHT depth = 2^IW entries of 2 bits.
- Read index = {bu_bp_history, if_nxt_pc[BP_LOCAL_BITS+ALIGN-1:ALIGN]}.
- Write index = {bu_bp_history, ex_pc[BP_LOCAL_BITS+ALIGN-1:ALIGN]}.
- Update value is computed from bu_bp_predict; the PHT is not re-read.
  - Taken: saturating increment, 11 stays 11.
  - Not taken: saturating decrement, 00 stays 00.
- Write enable = bu_bp_update & state==RUN. Writes take one cycle.
- Read latency 1: bp_bp_predict updates on the clock edge after if_nxt_pc is presented.
- When if_stall=1:
  - bp_bp_predict holds its value.
  - No new read is captured.
  - The captured read address is kept for re-presentation.
- Write/read collision (same index, same cycle, write enabled): bp_bp_predict takes the newly written value (write-first bypass).
- Init FSM has two states:
  - INIT: the sweep counter writes INIT_STATE to entry cnt each cycle. At cnt == depth-1 the FSM moves to RUN on the next edge. Sweep length is exactly 2^IW cycles.
  - RUN: normal operation; terminal state until reset.
- During INIT:
  - bp_init_busy=1.
  - bp_bp_predict=2'b00 (predict not taken).
  - bu_bp_update is ignored.
- Reset values: state=INIT, cnt=0, bp_bp_predict=2'b00, bp_init_busy=1.
- Reset asserted mid-sweep or mid-RUN restarts INIT from cnt=0; PHT contents are treated as unknown until the sweep completes.
- First RUN cycle: the read uses the normal path; the entry swept in the last INIT cycle is valid for reads from that cycle on.
- The PHT array has no reset (RAM-inferable); only the FSM, counter and output register are reset.

Decomposition:
- Shared package riscv_pkg gains the counter encodings BP_STRONG_NT=2'b00, BP_WEAK_NT=2'b01, BP_WEAK_T=2'b10, BP_STRONG_T=2'b11, plus the FSM state enum bp_state_t {BP_INIT, BP_RUN}.
- One sub-module: riscv_bp_ram.
  - Parameterised 1R1W synchronous RAM, ABITS=IW, DBITS=2.
  - Registered read with read-enable.
  - No reset.
  - Write-first bypass is done in riscv_bp, not in the RAM.

Test Plan:
- Reset, defaults (G=2, L=10): bp_init_busy high for exactly 4096 cycles after rstn rises, then low. Fetching 0x200 afterwards gives bp_bp_predict=2'b01; during init it reads 2'b00.
- Update: ex_pc=0x200, bu_bp_history=2'b00, bu_bp_predict=01, btaken=1, update=1. Then present if_nxt_pc=0x200 with history 00: predict 2'b10 one cycle later. Same PC with history 01 still gives 2'b01.
- Saturation:
  - Predict 11 + taken leaves the entry at 11.
  - Predict 00 + not-taken leaves the entry at 00.
  - Predict 10 + not-taken gives 01.
- Collision: update 0x300 (predict 01, taken) in the same cycle that if_nxt_pc=0x300 with the same history: next-cycle bp_bp_predict=2'b10, not 2'b01.
- Stall: bp_bp_predict=2'b10 at 0x200, then assert if_stall and change if_nxt_pc to 0x204 (entry 01). Output stays 2'b10 until if_stall drops, then shows 2'b01 one cycle later.
- Update issued during INIT is ignored (entry reads INIT_STATE afterwards). Reset pulsed at sweep cycle 2000 restarts busy for a full 4096 cycles.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core package: branch-predictor counter encodings, init FSM
// states and the 2-bit saturating counter update.
package riscv_pkg;

  localparam logic [1:0] BP_STRONG_NT = 2'b00;
  localparam logic [1:0] BP_WEAK_NT   = 2'b01;
  localparam logic [1:0] BP_WEAK_T    = 2'b10;
  localparam logic [1:0] BP_STRONG_T  = 2'b11;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_t;

  function automatic logic [1:0] bp_cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == BP_STRONG_T)  ? cnt : cnt + 2'd1;
    else       return (cnt == BP_STRONG_NT) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/riscv_bp_ram.sv
// 1R1W synchronous RAM with registered read and read-enable; no reset so it
// maps onto block RAM. Same-address read returns the old contents.
module riscv_bp_ram #(
  parameter int ABITS = 12,
  parameter int DBITS = 2
) (
  input  logic             clk,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DBITS-1:0] rdata,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DBITS-1:0] wdata
);

  logic [DBITS-1:0] mem [2**ABITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/riscv_bp.sv
// Gshare branch predictor: PHT indexed by {global history, PC bits}, swept to
// INIT_STATE after reset, updated from resolved branches in the branch unit.
module riscv_bp
  import riscv_pkg::*;
#(
  parameter int         XLEN           = 32,
  parameter int         BP_GLOBAL_BITS = 2,
  parameter int         BP_LOCAL_BITS  = 10,
  parameter int         HAS_RVC        = 0,
  parameter logic [1:0] INIT_STATE     = 2'b01
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      if_stall,
  input  logic [XLEN-1:0]           if_nxt_pc,
  output logic [1:0]                bp_bp_predict,
  output logic                      bp_init_busy,
  input  logic [XLEN-1:0]           ex_pc,
  input  logic                      bu_bp_update,
  input  logic                      bu_bp_btaken,
  input  logic [1:0]                bu_bp_predict,
  input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history
);

  localparam int ALIGN = (HAS_RVC != 0) ? 1 : 2;
  localparam int IW    = BP_GLOBAL_BITS + BP_LOCAL_BITS;
  localparam logic [IW-1:0] CNT_LAST = '1;

  bp_state_t     state, state_nxt;
  logic [IW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] ridx, widx, ram_waddr;
  logic [1:0]    upd_val, ram_wdata, ram_rdata, byp_val;
  logic          upd_we, ram_we, ram_re, byp_sel, run_q;

  assign ridx    = {bu_bp_history, if_nxt_pc[BP_LOCAL_BITS+ALIGN-1:ALIGN]};
  assign widx    = {bu_bp_history, ex_pc[BP_LOCAL_BITS+ALIGN-1:ALIGN]};
  assign upd_val = bp_cnt_next(bu_bp_predict, bu_bp_btaken);
  assign upd_we  = bu_bp_update & (state == BP_RUN);

  // The init sweep owns the write port until the FSM reaches RUN.
  assign ram_we    = (state == BP_INIT) | upd_we;
  assign ram_waddr = (state == BP_INIT) ? cnt : widx;
  assign ram_wdata = (state == BP_INIT) ? INIT_STATE : upd_val;
  assign ram_re    = ~if_stall;

  riscv_bp_ram #(.ABITS(IW), .DBITS(2)) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .raddr (ridx),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BP_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      BP_INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) state_nxt = BP_RUN;
      end
      default: state_nxt = BP_RUN;
    endcase
  end

  // Output-side registers: run_q masks reads captured during INIT; the bypass
  // pair replaces the RAM's stale read-before-write data on a collision.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q   <= 1'b0;
      byp_sel <= 1'b0;
      byp_val <= BP_STRONG_NT;
    end else if (!if_stall) begin
      run_q   <= (state == BP_RUN);
      byp_sel <= upd_we & (widx == ridx);
      byp_val <= upd_val;
    end
  end

  assign bp_bp_predict = !run_q ? BP_STRONG_NT : (byp_sel ? byp_val : ram_rdata);
  assign bp_init_busy  = (state == BP_INIT);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_nxt_pc, ex_pc};

endmodule

// File: tb/tb_riscv_bp.sv
// Scenario bench for riscv_bp: expected predictions come from a bench-side PHT
// model and are queued at fetch time, then popped one cycle later.
module tb_riscv_bp;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_stall = 1'b0;
  logic [31:0] if_nxt_pc = '0;
  logic [1:0]  bp_bp_predict;
  logic        bp_init_busy;
  logic [31:0] ex_pc = '0;
  logic        bu_bp_update = 1'b0;
  logic        bu_bp_btaken = 1'b0;
  logic [1:0]  bu_bp_predict = '0;
  logic [1:0]  bu_bp_history = '0;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] pht [DEPTH];
  logic [1:0] sb [$];
  logic [1:0] exp_v;
  bit         model_run = 1'b0;

  riscv_bp dut (
    .clk           (clk),
    .rstn          (rstn),
    .if_stall      (if_stall),
    .if_nxt_pc     (if_nxt_pc),
    .bp_bp_predict (bp_bp_predict),
    .bp_init_busy  (bp_init_busy),
    .ex_pc         (ex_pc),
    .bu_bp_update  (bu_bp_update),
    .bu_bp_btaken  (bu_bp_btaken),
    .bu_bp_predict (bu_bp_predict),
    .bu_bp_history (bu_bp_history)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int idx(input logic [31:0] pc, input logic [1:0] h);
    return int'({h, pc[11:2]});
  endfunction

  task automatic model_fill;
    for (int i = 0; i < DEPTH; i++) pht[i] = 2'b01;
    model_run = 1'b1;
  endtask

  task automatic issue_upd(input logic [31:0] pc, input logic [1:0] h,
                           input logic [1:0] pred, input logic tk);
    ex_pc = pc; bu_bp_history = h; bu_bp_predict = pred; bu_bp_btaken = tk;
    bu_bp_update = 1'b1;
    if (model_run) begin
      if (tk) pht[idx(pc, h)] = (pred == 2'b11) ? 2'b11 : pred + 2'd1;
      else    pht[idx(pc, h)] = (pred == 2'b00) ? 2'b00 : pred - 2'd1;
    end
  endtask

  task automatic present(input logic [31:0] pc, input logic [1:0] h);
    if_nxt_pc = pc; bu_bp_history = h;
    sb.push_back(model_run ? pht[idx(pc, h)] : 2'b00);
  endtask

  // Counts edges until busy drops; returns the sweep length seen.
  task automatic count_sweep(input int upd_at, output int n);
    n = 0;
    while (bp_init_busy && n < 5000) begin
      if (n == upd_at) issue_upd(32'h200, 2'b00, 2'b01, 1'b1);
      else bu_bp_update = 1'b0;
      step;
      n++;
    end
    bu_bp_update = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    model_run = 1'b0;
    rstn = 1'b0;
    step; step;
    n_cmp++;
    if (bp_init_busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy got %b want 1", bp_init_busy); end
    n_cmp++;
    if (bp_bp_predict !== 2'b00) begin n_bad++; $display("FAIL reset_predict got %b want 00", bp_bp_predict); end
    rstn = 1'b1;
    present(32'h200, 2'b00);
    step;
    n = 1;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL init_read got %b want %b", bp_bp_predict, exp_v); end
    while (bp_init_busy && n < 5000) begin step; n++; end
    n_cmp++;
    if (n !== DEPTH) begin n_bad++; $display("FAIL sweep_len got %0d want %0d", n, DEPTH); end
    model_fill();
    present(32'h200, 2'b00);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL post_init_read got %b want %b", bp_bp_predict, exp_v); end
  endtask

  task automatic test_update;
    issue_upd(32'h200, 2'b00, 2'b01, 1'b1);
    step;
    bu_bp_update = 1'b0;
    present(32'h200, 2'b00);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL update_h0 got %b want %b", bp_bp_predict, exp_v); end
    present(32'h200, 2'b01);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL update_h1 got %b want %b", bp_bp_predict, exp_v); end
  endtask

  task automatic test_saturation;
    logic [31:0] pcs  [3] = '{32'h208, 32'h20c, 32'h210};
    logic [1:0]  pred [3] = '{2'b11, 2'b00, 2'b10};
    logic        tk   [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue_upd(pcs[i], 2'b00, pred[i], tk[i]);
      step;
      bu_bp_update = 1'b0;
      present(pcs[i], 2'b00);
      step;
      exp_v = sb.pop_front();
      n_cmp++;
      if (bp_bp_predict !== exp_v)
        begin n_bad++; $display("FAIL saturation_%0d got %b want %b", i, bp_bp_predict, exp_v); end
    end
  endtask

  task automatic test_collision;
    issue_upd(32'h300, 2'b00, 2'b01, 1'b1);
    present(32'h300, 2'b00);
    step;
    bu_bp_update = 1'b0;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL collision got %b want %b", bp_bp_predict, exp_v); end
    present(32'h300, 2'b00);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL collision_reread got %b want %b", bp_bp_predict, exp_v); end
  endtask

  task automatic test_stall;
    logic [1:0] held;
    present(32'h200, 2'b00);
    step;
    held = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== held) begin n_bad++; $display("FAIL stall_pre got %b want %b", bp_bp_predict, held); end
    if_stall = 1'b1;
    if_nxt_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(held);
      step;
      exp_v = sb.pop_front();
      n_cmp++;
      if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL stall_hold_%0d got %b want %b", i, bp_bp_predict, exp_v); end
    end
    if_stall = 1'b0;
    present(32'h204, 2'b00);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL stall_release got %b want %b", bp_bp_predict, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pc;
    logic [1:0]  h;
    for (int i = 0; i < 60; i++) begin
      h = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        issue_upd(32'h400 + 32'($urandom_range(0, 3)) * 4, h, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      else
        bu_bp_update = 1'b0;
      pc = 32'h400 + 32'($urandom_range(0, 3)) * 4;
      present(pc, h);
      step;
      exp_v = sb.pop_front();
      n_cmp++;
      if (bp_bp_predict !== exp_v)
        begin n_bad++; $display("FAIL b2b_%0d pc=%h h=%0d got %b want %b", i, pc, h, bp_bp_predict, exp_v); end
    end
    bu_bp_update = 1'b0;
  endtask

  task automatic test_init_restart;
    int n;
    model_run = 1'b0;
    rstn = 1'b0;
    step;
    rstn = 1'b1;
    for (int i = 0; i < 2000; i++) step;
    n_cmp++;
    if (bp_init_busy !== 1'b1) begin n_bad++; $display("FAIL midsweep_busy got %b want 1", bp_init_busy); end
    rstn = 1'b0;
    #1;
    n_cmp++;
    if (bp_init_busy !== 1'b1 || bp_bp_predict !== 2'b00)
      begin n_bad++; $display("FAIL pulse_reset got busy=%b pred=%b want busy=1 pred=00", bp_init_busy, bp_bp_predict); end
    step;
    rstn = 1'b1;
    count_sweep(4093, n);
    n_cmp++;
    if (n !== DEPTH) begin n_bad++; $display("FAIL restart_sweep_len got %0d want %0d", n, DEPTH); end
    model_fill();
    present(32'h200, 2'b00);
    step;
    exp_v = sb.pop_front();
    n_cmp++;
    if (bp_bp_predict !== exp_v) begin n_bad++; $display("FAIL init_update_ignored got %b want %b", bp_bp_predict, exp_v); end
  endtask

  initial begin
    test_reset();
    test_update();
    test_stall();
    test_saturation();
    test_collision();
    test_back_to_back();
    test_init_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
